instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Consumes the program-counter stream and turns it into instructions for decode.
- Owns the fetch pointer. Issues word reads to instruction memory over a valid/ready request channel and collects in-order responses.
- Buffers fetched words with their PCs in a prefetch FIFO and hands them to decode over a valid/ready channel.
- A redirect (branch/jump target) flushes the buffer, discards in-flight responses and restarts fetch at the target.

Parameters:
ADDR_W, 32, fetch address width
DATA_W, 32, instruction word width
FIFO_DEPTH, 4, prefetch entries; power of two, >=2; also caps outstanding requests
RESET_ADDR, 32'h00000000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_addr
redirect_addr  in  ADDR_W  redirect target
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  request word address
mem_rsp_valid  in  1  read data valid, in request order, one per accepted request
mem_rsp_data  in  DATA_W  read data
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_data  out  DATA_W  instruction word
inst_pc  out  ADDR_W  address of inst_data
fetch_fault  out  1  sticky misaligned-redirect flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async):
  - fetch_ptr=RESET_ADDR, rsp_pc=RESET_ADDR.
  - FIFO empty; outstanding=0; drop_cnt=0; state=RUN.
  - Outputs: mem_req_valid=0, mem_req_addr=RESET_ADDR, inst_valid=0, inst_data=0, inst_pc=0, fetch_fault=0.
- States: RUN (drop_cnt=0), DRAIN (drop_cnt>0), FAULT (option only).
- Request issue:
  - mem_req_valid = state!=FAULT && !redirect_valid && (fifo_count+outstanding < FIFO_DEPTH).
  - mem_req_addr = fetch_ptr.
  - On valid&ready: fetch_ptr += 4, wrapping modulo 2^ADDR_W (0xFFFFFFFC -> 0x0); outstanding++.
  - Memory must tolerate withdrawal of mem_req_valid in a redirect cycle.
- Response:
  - Each mem_rsp_valid decrements outstanding.
  - If drop_cnt>0: data discarded, drop_cnt--; DRAIN -> RUN when drop_cnt reaches 0.
  - Otherwise {mem_rsp_data, rsp_pc} is pushed into the FIFO and rsp_pc += 4 (same wrap).
  - The capacity rule guarantees the FIFO never overflows.
  - A response arriving with outstanding=0 is a protocol error: ignored, never underflows.
- Latency: request accepted cycle t, response cycle t+k (k>=1), inst_valid visible at t+k+1 (no bypass).
- Decode side:
  - inst_valid = FIFO non-empty; inst_data/inst_pc come from the FIFO head.
  - Pop on inst_valid&inst_ready.
  - Push and pop in the same cycle are both legal; at full, no push can occur.
- Redirect (priority over everything in that cycle):
  - FIFO cleared; any pop that cycle is ignored.
  - fetch_ptr=rsp_pc=redirect_addr.
  - drop_cnt = outstanding minus 1 if a response arrives that cycle; that response is discarded.
  - state=DRAIN if drop_cnt>0, else RUN.
  - Redirect during DRAIN re-computes drop_cnt the same way.
- Back-to-back redirects: the last one wins; no request is issued in any redirect cycle.
- inst_valid stays 0 the cycle after a redirect.

Optional Feature:
- Macro: INSTR_FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_addr[1:0]!=0 enters FAULT: FIFO flushed, no further requests.
  - In-flight responses are still counted and discarded.
  - fetch_fault=1, sticky until reset; later redirects are ignored.
- Undefined:
  - redirect_addr[1:0] is forced to 0 before use.
  - fetch_fault tied to 0; FAULT state absent.

Test Plan:
1. Reset release, mem_req_ready=1, memory returns addr^0xA5A5A5A5 one cycle later, inst_ready=1 -> requests at 0x0,0x4,0x8,...; inst_pc 0x0,0x4,... each paired with the matching data; first inst_valid 2 cycles after the first accept.
2. inst_ready=0 with ready memory -> exactly 4 requests (0x0-0xC), FIFO full, mem_req_valid=0; one pop -> exactly one new request at 0x10.
3. Three responses in flight, redirect to 0x100 -> the three stale responses are dropped; next inst_pc=0x100 with the data for 0x100; DRAIN -> RUN after the third drop.
4. fetch_ptr=0xFFFFFFF8 via redirect -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; inst_pc follows the same wrap.
5. Redirect and response in the same cycle, outstanding=1 -> drop_cnt=0, response discarded, no instruction from the old stream appears.
6. With INSTR_FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> fetch_fault=1, mem_req_valid stays 0, inst_valid=0 until rst_n low. Without the macro -> fetch resumes at 0x100.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Owns the fetch pointer and turns it into a stream of instructions for
//   decode. Word reads go to instruction memory over a valid/ready request
//   channel. Responses come back in order, one per accepted request. They are
//   buffered with their PCs in a small prefetch FIFO and handed to decode over
//   a valid/ready channel. A redirect flushes the FIFO, marks every in-flight
//   response as stale, and restarts fetch at the target.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   redirect_valid  one-cycle pulse: restart fetch at redirect_addr
//   redirect_addr   redirect target
//   mem_req_valid   read request valid
//   mem_req_ready   memory accepts request
//   mem_req_addr    request word address (the fetch pointer)
//   mem_rsp_valid   read data valid, in request order
//   mem_rsp_data    read data
//   inst_valid      instruction available to decode (FIFO non-empty)
//   inst_ready      decode accepts instruction
//   inst_data       instruction word at FIFO head (0 when empty)
//   inst_pc         address of inst_data (0 when empty)
//   fetch_fault     sticky misaligned-redirect flag
//
// Configuration:
//   INSTR_FETCH_ALIGN_CHECK_EN
//     Defined:   a redirect with redirect_addr[1:0] != 0 enters a terminal
//                FAULT state. No further requests are made, stale responses
//                are still absorbed, and fetch_fault stays high until reset.
//     Undefined: redirect_addr[1:0] is cleared before use, and fetch_fault
//                is constant 0.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fetch_fault
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FAULT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1
    } state_t;
`endif

    // Sequential word address; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_W'(4);
    endfunction

    state_t state;
    state_t state_next;

    // Held low through reset and for the first cycle after it, so no request
    // is presented while reset is asserted.
    logic              fetch_en;

    logic [ADDR_W-1:0] fetch_ptr;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  drop_next;
    logic [PTR_W-1:0]  rd_idx;
    logic [PTR_W-1:0]  wr_idx;
    logic [OCC_W-1:0]  occupancy;

    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];

    logic              in_fault;
    logic              redir_take;
    logic [ADDR_W-1:0] redir_target;
    logic              req_fire;
    logic              rsp_take;
    logic              rsp_push;
    logic              rsp_drop;
    logic              pop;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    logic              fault_enter;
    assign in_fault    = (state == ST_FAULT);
    assign fault_enter = redir_take && (redirect_addr[1:0] != 2'b00);
`else
    assign in_fault    = 1'b0;
`endif

    // Once faulted, redirects are ignored entirely.
    assign redir_take   = redirect_valid && !in_fault;
    assign redir_target = redirect_addr & ~(ADDR_W'(3));

    assign req_fire = mem_req_valid && mem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored,
    // so the outstanding counter can never underflow.
    assign rsp_take = mem_rsp_valid && (outstanding != '0);

    // A response in a redirect cycle belongs to the old stream and is
    // discarded. Responses are also discarded while stale ones are draining
    // or after a fault.
    assign rsp_push = rsp_take && !redir_take && !in_fault && (drop_cnt == '0);
    assign rsp_drop = rsp_take && !redir_take && (drop_cnt != '0);

    // A pop in a redirect cycle is overridden by the flush.
    assign pop = inst_valid && inst_ready && !redir_take;

    // Buffered plus in-flight words never exceed FIFO_DEPTH, which is what
    // keeps pushes from overflowing the FIFO.
    assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding};

    assign mem_req_addr = fetch_ptr;
    assign inst_valid   = (fifo_count != '0);
    assign inst_data    = inst_valid ? data_mem[rd_idx] : '0;
    assign inst_pc      = inst_valid ? pc_mem[rd_idx]   : '0;

    // Every response still in flight at a redirect is stale. The one
    // arriving in the redirect cycle is discarded on the spot, so it is
    // not counted again.
    always_comb begin
        drop_next = drop_cnt;
        if (redir_take) begin
            drop_next = outstanding - CNT_W'(rsp_take);
        end else if (rsp_drop) begin
            drop_next = drop_cnt - CNT_W'(1);
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN, ST_DRAIN: state_next = (drop_next != '0) ? ST_DRAIN : ST_RUN;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
            ST_FAULT:         state_next = ST_FAULT;
`endif
            default:          state_next = ST_RUN;
        endcase
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        if (fault_enter) begin
            state_next = ST_FAULT;
        end
`endif
    end

    // ---------------- FSM: outputs ----------------
    // The request is withdrawn combinationally in any redirect cycle, so the
    // old fetch pointer is never accepted alongside a redirect.
    always_comb begin
        mem_req_valid = fetch_en && !in_fault && !redirect_valid
                        && (occupancy < OCC_W'(FIFO_DEPTH));
        fetch_fault   = in_fault;
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_en    <= 1'b0;
            fetch_ptr   <= RESET_ADDR;
            rsp_pc      <= RESET_ADDR;
            fifo_count  <= '0;
            rd_idx      <= '0;
            wr_idx      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            fetch_en    <= 1'b1;
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_take);
            drop_cnt    <= drop_next;
            if (redir_take) begin
                fetch_ptr  <= redir_target;
                rsp_pc     <= redir_target;
                fifo_count <= '0;
                rd_idx     <= '0;
                wr_idx     <= '0;
            end else begin
                if (req_fire) begin
                    fetch_ptr <= next_word(fetch_ptr);
                end
                if (rsp_push) begin
                    rsp_pc <= next_word(rsp_pc);
                    wr_idx <= wr_idx + PTR_W'(1);
                end
                if (pop) begin
                    rd_idx <= rd_idx + PTR_W'(1);
                end
                fifo_count <= fifo_count + CNT_W'(rsp_push) - CNT_W'(pop);
            end
        end
    end

    // ---------------- FIFO storage ----------------
    // No reset here: the FIFO contents are only visible while fifo_count
    // says they are valid.
    always_ff @(posedge clk) begin
        if (rsp_push) begin
            data_mem[wr_idx] <= mem_rsp_data;
            pc_mem[wr_idx]   <= rsp_pc;
        end
    end

endmodule
